// File: rtl/cr_tlvp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cr_tlvp_pkg
// Brief    : Shared constants, FSM states and helpers for the TLV parser user side.
// Revision : 1.0 - initial release
// ============================================================================
package cr_tlvp_pkg;

  localparam int CR_TLVP_DROP_MASK_W = 32;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    IN_TLV = 1'b1
  } tlvp_xfer_state_e;

  // Types at or above the mask width can never be selected for dropping.
  function automatic logic tlvp_mask_hit(input logic [CR_TLVP_DROP_MASK_W-1:0] mask,
                                         input logic [31:0]                    typen);
    return (typen < 32'(CR_TLVP_DROP_MASK_W)) ? mask[typen[4:0]] : 1'b0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cr_tlvp_usr_xfer_if.sv
`default_nettype none
// ============================================================================
// Module   : cr_tlvp_usr_xfer_if
// Brief    : User inbound (pop) and outbound (push) FIFO ports of the TLV parser.
// Revision : 1.0 - initial release
// ============================================================================
interface cr_tlvp_usr_xfer_if #(
  parameter int DATA_W = 64,
  parameter int TYPE_W = 8
);
  logic              usr_ib_empty;
  logic              usr_ib_rd;
  logic              usr_ib_sot;
  logic              usr_ib_eot;
  logic [TYPE_W-1:0] usr_ib_typen;
  logic [DATA_W-1:0] usr_ib_data;

  logic              usr_ob_full;
  logic              usr_ob_wr;
  logic              usr_ob_sot;
  logic              usr_ob_eot;
  logic [TYPE_W-1:0] usr_ob_typen;
  logic [DATA_W-1:0] usr_ob_data;

  // master = the mover; slave = the FIFO side
  modport master (
    input  usr_ib_empty, usr_ib_sot, usr_ib_eot, usr_ib_typen, usr_ib_data, usr_ob_full,
    output usr_ib_rd, usr_ob_wr, usr_ob_sot, usr_ob_eot, usr_ob_typen, usr_ob_data
  );

  modport slave (
    output usr_ib_empty, usr_ib_sot, usr_ib_eot, usr_ib_typen, usr_ib_data, usr_ob_full,
    input  usr_ib_rd, usr_ob_wr, usr_ob_sot, usr_ob_eot, usr_ob_typen, usr_ob_data
  );
endinterface
`default_nettype wire

// File: rtl/cr_tlvp_usr_xfer_oreg.sv
`default_nettype none
// ============================================================================
// Module   : cr_tlvp_usr_xfer_oreg
// Brief    : Single-entry output register with outbound wr/full handshake.
// Revision : 1.0 - initial release
// ============================================================================
module cr_tlvp_usr_xfer_oreg #(
  parameter int DATA_W = 64,
  parameter int TYPE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              in_sot,
  input  logic              in_eot,
  input  logic [TYPE_W-1:0] in_typen,
  input  logic [DATA_W-1:0] in_data,
  input  logic              ob_full,
  output logic              ob_wr,
  output logic              ob_sot,
  output logic              ob_eot,
  output logic [TYPE_W-1:0] ob_typen,
  output logic [DATA_W-1:0] ob_data,
  output logic              ob_vld,
  output logic              slot_free
);

  logic              r_vld;
  logic              r_sot;
  logic              r_eot;
  logic [TYPE_W-1:0] r_typen;
  logic [DATA_W-1:0] r_data;
  logic              w_wr;

  assign w_wr      = r_vld & ~ob_full;
  assign slot_free = ~r_vld | ~ob_full;

  // A load in the same cycle as a write-out simply replaces the departing word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld   <= 1'b0;
      r_sot   <= 1'b0;
      r_eot   <= 1'b0;
      r_typen <= '0;
      r_data  <= '0;
    end else begin
      if (load) begin
        r_vld   <= 1'b1;
        r_sot   <= in_sot;
        r_eot   <= in_eot;
        r_typen <= in_typen;
        r_data  <= in_data;
      end else if (w_wr) begin
        r_vld   <= 1'b0;
      end
    end
  end

  assign ob_wr    = w_wr;
  assign ob_sot   = r_sot;
  assign ob_eot   = r_eot;
  assign ob_typen = r_typen;
  assign ob_data  = r_data;
  assign ob_vld   = r_vld;

endmodule
`default_nettype wire

// File: rtl/cr_tlvp_usr_xfer.sv
`default_nettype none
// ============================================================================
// Module   : cr_tlvp_usr_xfer
// Brief    : Moves TLVs from the user inbound FIFO to the outbound FIFO, dropping
//            masked types, checking sot/eot framing and counting TLVs.
// Revision : 1.0 - initial release
// ============================================================================
module cr_tlvp_usr_xfer
  import cr_tlvp_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int TYPE_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic [CR_TLVP_DROP_MASK_W-1:0] drop_mask,
  cr_tlvp_usr_xfer_if.master             usr,
  output logic [CNT_W-1:0]               tlv_cnt,
  output logic [CNT_W-1:0]               drop_cnt,
  output logic                           framing_err,
  output logic                           idle
);

  tlvp_xfer_state_e r_state;
  tlvp_xfer_state_e w_state_nxt;
  logic             r_drop_cur;
  logic             r_framing_err;
  logic [CNT_W-1:0] r_tlv_cnt;
  logic [CNT_W-1:0] r_drop_cnt;

  logic w_mask_hit;
  logic w_drop_now;
  logic w_bad;
  logic w_pop;
  logic w_load;
  logic w_slot_free;
  logic w_ob_vld;
  logic w_err_nxt;

  // The mask is sampled only at sot; later words follow the latched decision.
  assign w_mask_hit = tlvp_mask_hit(drop_mask, 32'(usr.usr_ib_typen));
  assign w_drop_now = usr.usr_ib_sot ? w_mask_hit : r_drop_cur;
  assign w_bad      = (r_state == IDLE) & ~usr.usr_ib_sot;
  assign w_pop      = ~rst & enable & ~usr.usr_ib_empty & (w_drop_now | w_slot_free | w_bad);
  assign w_load     = w_pop & ~w_bad & ~w_drop_now;

  assign usr.usr_ib_rd = w_pop;

  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = 1'b0;
    if (w_pop) begin
      if (usr.usr_ib_sot) begin
        w_state_nxt = usr.usr_ib_eot ? IDLE : IN_TLV;
        w_err_nxt   = (r_state == IN_TLV);
      end else if (r_state == IDLE) begin
        w_err_nxt   = 1'b1;
      end else begin
        w_state_nxt = usr.usr_ib_eot ? IDLE : IN_TLV;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_drop_cur    <= 1'b0;
      r_framing_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_framing_err <= w_err_nxt;
      if (w_pop && usr.usr_ib_sot) begin
        r_drop_cur <= w_mask_hit;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tlv_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (usr.usr_ob_wr && usr.usr_ob_eot) begin
        r_tlv_cnt <= r_tlv_cnt + CNT_W'(1);
      end
      if (w_pop && !w_bad && w_drop_now && usr.usr_ib_eot) begin
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
    end
  end

  cr_tlvp_usr_xfer_oreg #(
    .DATA_W (DATA_W),
    .TYPE_W (TYPE_W)
  ) u_oreg (
    .clk       (clk),
    .rst       (rst),
    .load      (w_load),
    .in_sot    (usr.usr_ib_sot),
    .in_eot    (usr.usr_ib_eot),
    .in_typen  (usr.usr_ib_typen),
    .in_data   (usr.usr_ib_data),
    .ob_full   (usr.usr_ob_full),
    .ob_wr     (usr.usr_ob_wr),
    .ob_sot    (usr.usr_ob_sot),
    .ob_eot    (usr.usr_ob_eot),
    .ob_typen  (usr.usr_ob_typen),
    .ob_data   (usr.usr_ob_data),
    .ob_vld    (w_ob_vld),
    .slot_free (w_slot_free)
  );

  assign tlv_cnt     = r_tlv_cnt;
  assign drop_cnt    = r_drop_cnt;
  assign framing_err = r_framing_err;
  assign idle        = (r_state == IDLE) & ~w_ob_vld;

endmodule
`default_nettype wire

// File: tb/tb_cr_tlvp_usr_xfer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cr_tlvp_usr_xfer
// Brief    : Self-checking bench: FIFO models plus a TLV-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cr_tlvp_usr_xfer;

  localparam int DATA_W = 64;
  localparam int TYPE_W = 8;
  localparam int CNT_W  = 16;

  typedef struct packed {
    logic              sot;
    logic              eot;
    logic [TYPE_W-1:0] typen;
    logic [DATA_W-1:0] data;
  } word_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [31:0]      drop_mask;
  logic [CNT_W-1:0] tlv_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic             framing_err;
  logic             idle;

  cr_tlvp_usr_xfer_if #(.DATA_W(DATA_W), .TYPE_W(TYPE_W)) usr();

  cr_tlvp_usr_xfer #(.DATA_W(DATA_W), .TYPE_W(TYPE_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .drop_mask   (drop_mask),
    .usr         (usr),
    .tlv_cnt     (tlv_cnt),
    .drop_cnt    (drop_cnt),
    .framing_err (framing_err),
    .idle        (idle)
  );

  always #5 clk = ~clk;

  word_t            ib_q[$];
  word_t            exp_q[$];
  int               pop_cyc[$];
  int               wr_cyc[$];
  int               cyc, pop_cnt, wr_cnt, fe_cnt;
  int               checks, errors;
  logic [CNT_W-1:0] exp_tlv, exp_drop;

  // Inbound FIFO model (FWFT) and outbound scoreboard, sampled mid-cycle.
  initial begin
    word_t e;
    usr.usr_ib_empty = 1'b1;
    usr.usr_ib_sot   = 1'b0;
    usr.usr_ib_eot   = 1'b0;
    usr.usr_ib_typen = '0;
    usr.usr_ib_data  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (ib_q.size() > 0) begin
        usr.usr_ib_empty = 1'b0;
        {usr.usr_ib_sot, usr.usr_ib_eot, usr.usr_ib_typen, usr.usr_ib_data} = ib_q[0];
      end else begin
        usr.usr_ib_empty = 1'b1;
      end
      #4;
      if (usr.usr_ib_rd) begin
        checks++;
        if (ib_q.size() == 0) begin
          errors++;
          $display("FAIL pop_empty: rd=1 with inbound FIFO empty, required rd=0 (cycle %0d)", cyc);
        end else begin
          void'(ib_q.pop_front());
          pop_cnt++;
          pop_cyc.push_back(cyc);
        end
      end
      if (usr.usr_ob_wr) begin
        wr_cnt++;
        wr_cyc.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL ob_unexpected: wrote %h, required no write (cycle %0d)",
                   {usr.usr_ob_sot, usr.usr_ob_eot, usr.usr_ob_typen, usr.usr_ob_data}, cyc);
        end else begin
          e = exp_q.pop_front();
          if ({usr.usr_ob_sot, usr.usr_ob_eot, usr.usr_ob_typen, usr.usr_ob_data} !== e) begin
            errors++;
            $display("FAIL ob_word: got %h, required %h (cycle %0d)",
                     {usr.usr_ob_sot, usr.usr_ob_eot, usr.usr_ob_typen, usr.usr_ob_data}, e, cyc);
          end
        end
      end
      if (framing_err === 1'b1) fe_cnt++;
    end
  end

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation time limit reached, %0d errors so far", errors);
    $fatal(1, "watchdog");
  end

  function automatic bit model_drop(input logic [TYPE_W-1:0] t, input logic [31:0] m);
    return (t < 32) && m[t[4:0]];
  endfunction

  task automatic push_tlv(input logic [TYPE_W-1:0] t, input int len, input logic [31:0] m);
    word_t w;
    bit    d;
    d = model_drop(t, m);
    for (int i = 0; i < len; i++) begin
      w.sot   = (i == 0);
      w.eot   = (i == len - 1);
      w.typen = t;
      w.data  = {$urandom, $urandom};
      ib_q.push_back(w);
      if (!d) exp_q.push_back(w);
    end
    if (d) exp_drop++;
    else   exp_tlv++;
  endtask

  task automatic wait_drain(input int budget, input bit stall);
    int n;
    bit done;
    n    = 0;
    done = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      if (stall) begin
        usr.usr_ob_full = ($urandom_range(0, 3) == 0);
        enable          = ($urandom_range(0, 4) != 0);
      end else begin
        usr.usr_ob_full = 1'b0;
        enable          = 1'b1;
      end
      #6;
      n++;
      if (ib_q.size() == 0 && idle === 1'b1) done = 1;
    end
    @(negedge clk);
    usr.usr_ob_full = 1'b0;
    enable          = 1'b1;
    #6;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: %0d words still queued, required 0 within %0d cycles", ib_q.size(), budget);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_missing: %0d expected words never written, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset;
    rst             = 1'b1;
    enable          = 1'b0;
    drop_mask       = '0;
    usr.usr_ob_full = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({usr.usr_ob_wr, usr.usr_ib_rd, framing_err, idle} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_flags: wr/rd/ferr/idle=%b, required 0001", {usr.usr_ob_wr, usr.usr_ib_rd, framing_err, idle});
    end
    checks++;
    if ({tlv_cnt, drop_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_cnt: tlv=%0d drop=%0d, required 0 0", tlv_cnt, drop_cnt);
    end
    checks++;
    if ({usr.usr_ob_sot, usr.usr_ob_eot, usr.usr_ob_typen, usr.usr_ob_data} !== '0) begin
      errors++;
      $display("FAIL reset_ob: fields=%h, required 0", {usr.usr_ob_sot, usr.usr_ob_eot, usr.usr_ob_typen, usr.usr_ob_data});
    end
    @(negedge clk);
    rst    = 1'b0;
    enable = 1'b1;
  endtask

  task automatic test_stream;
    int fe0;
    bit lat_ok;
    fe0 = fe_cnt;
    drop_mask = '0;
    pop_cyc.delete();
    wr_cyc.delete();
    for (int t = 1; t <= 3; t++) push_tlv(TYPE_W'(t), 4, 32'h0);
    wait_drain(100, 0);
    checks++;
    if (wr_cyc.size() != 12 || pop_cyc.size() != 12) begin
      errors++;
      $display("FAIL stream_count: writes=%0d pops=%0d, required 12 12", wr_cyc.size(), pop_cyc.size());
    end else begin
      lat_ok = 1;
      for (int i = 0; i < 12; i++) if (wr_cyc[i] != pop_cyc[i] + 1) lat_ok = 0;
      checks++;
      if (!lat_ok) begin
        errors++;
        $display("FAIL stream_latency: first wr cycle %0d for pop cycle %0d, required pop+1 for every word", wr_cyc[0], pop_cyc[0]);
      end
    end
    checks++;
    if (tlv_cnt !== exp_tlv || drop_cnt !== exp_drop) begin
      errors++;
      $display("FAIL stream_cnt: tlv=%0d drop=%0d, required %0d %0d", tlv_cnt, drop_cnt, exp_tlv, exp_drop);
    end
    checks++;
    if (fe_cnt != fe0) begin
      errors++;
      $display("FAIL stream_ferr: %0d pulses, required 0", fe_cnt - fe0);
    end
  endtask

  task automatic test_drop;
    bit b2b;
    drop_mask = 32'h4;
    pop_cyc.delete();
    wr_cyc.delete();
    for (int t = 1; t <= 3; t++) push_tlv(TYPE_W'(t), 4, 32'h4);
    wait_drain(100, 0);
    checks++;
    if (wr_cyc.size() != 8) begin
      errors++;
      $display("FAIL drop_writes: %0d, required 8", wr_cyc.size());
    end
    b2b = (pop_cyc.size() == 12);
    for (int i = 1; i < pop_cyc.size(); i++) if (pop_cyc[i] != pop_cyc[i-1] + 1) b2b = 0;
    checks++;
    if (!b2b) begin
      errors++;
      $display("FAIL drop_b2b: %0d pops not back-to-back, required 12 consecutive", pop_cyc.size());
    end
    checks++;
    if (tlv_cnt !== exp_tlv || drop_cnt !== exp_drop) begin
      errors++;
      $display("FAIL drop_cnt: tlv=%0d drop=%0d, required %0d %0d", tlv_cnt, drop_cnt, exp_tlv, exp_drop);
    end
    drop_mask = '0;
  endtask

  task automatic test_full_stall;
    int w0, p0, n, ws;
    bit cont;
    drop_mask = '0;
    w0 = wr_cnt;
    wr_cyc.delete();
    push_tlv(TYPE_W'(4), 12, 32'h0);
    n = 0;
    while (wr_cnt < w0 + 3 && n < 50) begin
      @(negedge clk);
      #6;
      n++;
    end
    @(negedge clk);
    usr.usr_ob_full = 1'b1;
    p0 = pop_cnt;
    for (int i = 0; i < 5; i++) begin
      #3;
      checks++;
      if (usr.usr_ob_wr !== 1'b0) begin
        errors++;
        $display("FAIL stall_wr: wr=%b in stall cycle %0d, required 0", usr.usr_ob_wr, i);
      end
      @(negedge clk);
    end
    usr.usr_ob_full = 1'b0;
    checks++;
    if (pop_cnt - p0 > 1) begin
      errors++;
      $display("FAIL stall_pops: %0d pops while full, required <= 1", pop_cnt - p0);
    end
    ws = wr_cyc.size();
    wait_drain(100, 0);
    cont = 1;
    for (int i = ws + 1; i < wr_cyc.size(); i++) if (wr_cyc[i] != wr_cyc[i-1] + 1) cont = 0;
    checks++;
    if (!cont || wr_cnt - w0 != 12) begin
      errors++;
      $display("FAIL stall_resume: %0d writes (consecutive=%0d), required 12 at 1/cycle", wr_cnt - w0, cont);
    end
    checks++;
    if (tlv_cnt !== exp_tlv) begin
      errors++;
      $display("FAIL stall_cnt: tlv=%0d, required %0d", tlv_cnt, exp_tlv);
    end
  endtask

  task automatic test_framing;
    int    fe0, w0;
    word_t w;
    fe0 = fe_cnt;
    w0  = wr_cnt;
    drop_mask = '0;
    w = '{sot: 1'b0, eot: 1'b1, typen: TYPE_W'(3), data: {$urandom, $urandom}};
    ib_q.push_back(w);
    wait_drain(50, 0);
    checks++;
    if (fe_cnt != fe0 + 1) begin
      errors++;
      $display("FAIL ferr_idle: %0d pulse cycles, required 1", fe_cnt - fe0);
    end
    checks++;
    if (wr_cnt != w0 || tlv_cnt !== exp_tlv) begin
      errors++;
      $display("FAIL ferr_idle_fwd: %0d writes tlv=%0d, required 0 writes tlv=%0d", wr_cnt - w0, tlv_cnt, exp_tlv);
    end
    // Truncated TLV: its two words go out but it is never counted.
    for (int i = 0; i < 2; i++) begin
      w = '{sot: (i == 0), eot: 1'b0, typen: TYPE_W'(5), data: {$urandom, $urandom}};
      ib_q.push_back(w);
      exp_q.push_back(w);
    end
    push_tlv(TYPE_W'(6), 3, 32'h0);
    wait_drain(50, 0);
    checks++;
    if (fe_cnt != fe0 + 2) begin
      errors++;
      $display("FAIL ferr_sot: %0d pulse cycles total, required 2", fe_cnt - fe0);
    end
    checks++;
    if (tlv_cnt !== exp_tlv || wr_cnt != w0 + 5) begin
      errors++;
      $display("FAIL ferr_sot_cnt: tlv=%0d writes=%0d, required tlv=%0d writes=5", tlv_cnt, wr_cnt - w0, exp_tlv);
    end
  endtask

  task automatic test_reset_mid;
    int p0, n, fe0;
    drop_mask = '0;
    p0 = pop_cnt;
    push_tlv(TYPE_W'(7), 6, 32'h0);
    n = 0;
    while (pop_cnt < p0 + 3 && n < 50) begin
      @(negedge clk);
      #6;
      n++;
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({usr.usr_ob_wr, usr.usr_ib_rd, framing_err, idle} !== 4'b0001 || {tlv_cnt, drop_cnt} !== '0) begin
      errors++;
      $display("FAIL rst_async: wr/rd/ferr/idle=%b tlv=%0d drop=%0d, required 0001 0 0",
               {usr.usr_ob_wr, usr.usr_ib_rd, framing_err, idle}, tlv_cnt, drop_cnt);
    end
    checks++;
    if ({usr.usr_ob_sot, usr.usr_ob_eot, usr.usr_ob_typen, usr.usr_ob_data} !== '0) begin
      errors++;
      $display("FAIL rst_async_ob: fields=%h, required 0", {usr.usr_ob_sot, usr.usr_ob_eot, usr.usr_ob_typen, usr.usr_ob_data});
    end
    ib_q.delete();
    exp_q.delete();
    exp_tlv  = '0;
    exp_drop = '0;
    @(negedge clk);
    rst = 1'b0;
    #6;
    checks++;
    if (idle !== 1'b1) begin
      errors++;
      $display("FAIL rst_idle: idle=%b after release, required 1", idle);
    end
    fe0 = fe_cnt;
    push_tlv(TYPE_W'(9), 3, 32'h0);
    wait_drain(50, 0);
    checks++;
    if (tlv_cnt !== exp_tlv || fe_cnt != fe0) begin
      errors++;
      $display("FAIL rst_next: tlv=%0d ferr=%0d, required %0d 0", tlv_cnt, fe_cnt - fe0, exp_tlv);
    end
  endtask

  task automatic test_random;
    int          fe0;
    logic [31:0] m;
    fe0 = fe_cnt;
    for (int r = 0; r < 4; r++) begin
      m = $urandom;
      drop_mask = m;
      for (int k = 0; k < 15; k++) push_tlv(TYPE_W'($urandom_range(0, 40)), $urandom_range(1, 4), m);
      wait_drain(2000, 1);
      checks++;
      if (tlv_cnt !== exp_tlv || drop_cnt !== exp_drop) begin
        errors++;
        $display("FAIL random_cnt: round %0d tlv=%0d drop=%0d, required %0d %0d", r, tlv_cnt, drop_cnt, exp_tlv, exp_drop);
      end
    end
    checks++;
    if (fe_cnt != fe0) begin
      errors++;
      $display("FAIL random_ferr: %0d pulses, required 0", fe_cnt - fe0);
    end
    drop_mask = '0;
  endtask

  task automatic test_drop_wrap;
    int               n;
    logic [CNT_W-1:0] t0;
    t0 = exp_tlv;
    drop_mask = 32'h1;
    n = int'(CNT_W'(16'hFFFF - exp_drop));
    for (int i = 0; i < n; i++) push_tlv(TYPE_W'(0), 1, 32'h1);
    wait_drain(n + 100, 0);
    checks++;
    if (drop_cnt !== 16'hFFFF || drop_cnt !== exp_drop) begin
      errors++;
      $display("FAIL wrap_preset: drop=%0d, required 65535", drop_cnt);
    end
    push_tlv(TYPE_W'(0), 1, 32'h1);
    wait_drain(50, 0);
    checks++;
    if (drop_cnt !== exp_drop) begin
      errors++;
      $display("FAIL wrap_zero: drop=%0d, required %0d", drop_cnt, exp_drop);
    end
    checks++;
    if (tlv_cnt !== t0) begin
      errors++;
      $display("FAIL wrap_tlv: tlv=%0d, required %0d", tlv_cnt, t0);
    end
    drop_mask = '0;
  endtask

  initial begin
    exp_tlv  = '0;
    exp_drop = '0;
    test_reset;
    test_stream;
    test_drop;
    test_full_stall;
    test_framing;
    test_reset_mid;
    test_random;
    test_drop_wrap;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
